// File: rtl/rom_serial_loader_rx.sv
// Serial-to-parallel byte receiver for the i4001 ROM image load path, with a
// valid/ready byte output. Optional even-parity 9th bit: `ROM_LOADER_PARITY_EN.
module rom_serial_loader_rx #(
    parameter int unsigned BITS_PER_WORD = 8,
    parameter int unsigned ADDR_W        = 8,
    parameter bit          LSB_FIRST     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sdi,
    input  logic                     sdv,
    input  logic                     sof,
    output logic [BITS_PER_WORD-1:0] data,
    output logic [ADDR_W-1:0]        addr,
    output logic                     valid,
    input  logic                     ready,
    output logic                     wrap,
    output logic                     ovr
`ifdef ROM_LOADER_PARITY_EN
    ,
    output logic                     perr
`endif
);

`ifdef ROM_LOADER_PARITY_EN
    localparam int unsigned FRAME = BITS_PER_WORD + 1;
`else
    localparam int unsigned FRAME = BITS_PER_WORD;
`endif
    localparam int unsigned CW      = $clog2(FRAME + 1);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD_SHIFT
    } state_e;

    state_e                   st_q, st_d;
    logic [CW-1:0]            cnt_q, cnt_d, cnt_n;
    logic [BITS_PER_WORD-1:0] sr_q, sr_d, sr_base, sr_n, byte_c;
    logic [BITS_PER_WORD-1:0] data_q, data_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     valid_q, valid_d;
    logic                     wrap_q, wrap_d;
    logic                     ovr_q, ovr_d;
    logic                     sofp_q, sofp_d;
    logic                     first, done, accept;
`ifdef ROM_LOADER_PARITY_EN
    logic                     perr_q, perr_d;
    logic                     par_bad;
`endif

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        wrap_d  = wrap_q;
        ovr_d   = ovr_q;
        sofp_d  = sofp_q;
`ifdef ROM_LOADER_PARITY_EN
        perr_d  = perr_q;
        par_bad = 1'b0;
`endif
        done    = 1'b0;
        accept  = valid_q & ready;

        // A new frame starts either on sof or on the first strobe after idle.
        first   = sof || (st_q == IDLE);
        cnt_n   = first ? CW'(1) : cnt_q + CW'(1);
        sr_base = first ? '0 : sr_q;
        sr_n    = LSB_FIRST ? {sdi, sr_base[BITS_PER_WORD-1:1]}
                            : {sr_base[BITS_PER_WORD-2:0], sdi};
`ifdef ROM_LOADER_PARITY_EN
        byte_c  = sr_q;
`else
        byte_c  = sr_n;
`endif

        if (sdv) begin
            sr_d = sr_n;
            if (cnt_n == FRAME_C) begin
                done  = 1'b1;
                cnt_d = '0;
`ifdef ROM_LOADER_PARITY_EN
                par_bad = ((^sr_q) != sdi);
`endif
            end else begin
                cnt_d = cnt_n;
            end
        end

        if (accept) begin
            valid_d = 1'b0;
            if (sofp_q) begin
                addr_d = '0;
                sofp_d = 1'b0;
            end else begin
                if (addr_q == '1) wrap_d = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        // sof restarts addressing, but a byte still on offer keeps its address.
        if (sdv && sof) begin
            if (valid_q && !accept) begin
                sofp_d = 1'b1;
            end else begin
                addr_d = '0;
                sofp_d = 1'b0;
            end
        end

        if (done) begin
`ifdef ROM_LOADER_PARITY_EN
            if (par_bad) perr_d = 1'b1;
            else
`endif
            if (!valid_q || accept) begin
                data_d  = byte_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (cnt_d == '0)  st_d = IDLE;
        else if (valid_d) st_d = HOLD_SHIFT;
        else              st_d = SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            ovr_q   <= 1'b0;
            sofp_q  <= 1'b0;
`ifdef ROM_LOADER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ovr_q   <= ovr_d;
            sofp_q  <= sofp_d;
`ifdef ROM_LOADER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign data  = data_q;
    assign addr  = addr_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;
    assign ovr   = ovr_q;
`ifdef ROM_LOADER_PARITY_EN
    assign perr  = perr_q;
`endif

endmodule
